// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the two-stage pipelined ALU: the opcode map,
// the flag bundle carried alongside each result, and the opcode width.
package alu_pipe_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_XOR = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_NOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_ADC = 4'd9
    } opcode_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic o;
    } flags_t;

    // Everything above ADC is an unmapped encoding.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_ADC);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result bundle between operand fetch, the ALU pipe and writeback.
// The slave side is the ALU; the master side issues operations and drains results.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    import alu_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_cin;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_z;
    logic              out_n;
    logic              out_c;
    logic              out_o;
    logic              out_illegal;

    logic              clr_sticky;
    logic              sticky_o;

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_cin, out_ready, clr_sticky,
        input  in_ready, out_valid, out_result, out_z, out_n, out_c, out_o,
               out_illegal, sticky_o
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_cin, out_ready, clr_sticky,
        output in_ready, out_valid, out_result, out_z, out_n, out_c, out_o,
               out_illegal, sticky_o
    );

endinterface

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath sitting between the operand and result registers.
// One shared WIDTH+1 bit adder serves ADD, SUB and ADC; SUB feeds the
// inverted B operand with a forced carry-in so its carry-out means "no borrow".
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output flags_t           flags,
    output logic             illegal
);

    logic             is_sub;
    logic             is_adc;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    assign is_sub   = (opcode == OP_SUB);
    assign is_adc   = (opcode == OP_ADC);
    assign b_eff    = is_sub ? ~b : b;
    assign carry_in = is_sub | (is_adc & cin);
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    assign sh       = b[SHW-1:0];

    // Pick the result for the opcode; carry and overflow only mean something for the adder ops.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADC: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  res = a ^ b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = $unsigned($signed(a) >>> sh);
            default: res = '0;
        endcase
    end

    assign result  = res;
    assign flags.z = (res == '0);
    assign flags.n = res[WIDTH-1];
    assign flags.c = carry;
    assign flags.o = ovf;
    assign illegal = !op_is_legal(opcode);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU. S1 holds the accepted operation, S2 holds the
// computed result and flags. S2 stalls only while writeback withholds
// out_ready, and S1 drains into S2 whenever S2 is empty or emptying, so
// in_ready passes out_ready straight through when the pipe is full.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);

    logic              s1_valid;
    logic [OP_W-1:0]   s1_opcode;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic              s1_cin;

    logic              s2_valid;
    logic [WIDTH-1:0]  s2_result;
    flags_t            s2_flags;
    logic              s2_illegal;

    logic              sticky;

    logic [WIDTH-1:0]  core_result;
    flags_t            core_flags;
    logic              core_illegal;

    logic              s2_open;
    logic              s1_advance;
    logic              in_ready;
    logic              accept;
    logic              out_xfer;

    assign s2_open    = !s2_valid || bus.out_ready;
    assign in_ready   = !s1_valid || s2_open;
    assign accept     = bus.in_valid && in_ready;
    assign s1_advance = s1_valid && s2_open;
    assign out_xfer   = s2_valid && bus.out_ready;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .opcode  (s1_opcode),
        .a       (s1_a),
        .b       (s1_b),
        .cin     (s1_cin),
        .result  (core_result),
        .flags   (core_flags),
        .illegal (core_illegal)
    );

    // S1: capture a new operation on accept; empties when it moves on with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_cin    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_opcode <= bus.in_opcode;
                s1_a      <= bus.in_a;
                s1_b      <= bus.in_b;
                s1_cin    <= bus.in_cin;
            end
        end
    end

    // S2: load the datapath output when open; otherwise hold so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_flags   <= '0;
            s2_illegal <= 1'b0;
        end else begin
            if (s2_open) begin
                s2_valid <= s1_valid;
            end
            if (s1_advance) begin
                s2_result  <= core_result;
                s2_flags   <= core_flags;
                s2_illegal <= core_illegal;
            end
        end
    end

    // Sticky overflow: an overflowing output transfer sets it even when a clear arrives together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else begin
            sticky <= (sticky && !bus.clr_sticky) || (out_xfer && s2_flags.o);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = s2_valid;
    assign bus.out_result  = s2_result;
    assign bus.out_z       = s2_flags.z;
    assign bus.out_n       = s2_flags.n;
    assign bus.out_c       = s2_flags.c;
    assign bus.out_o       = s2_flags.o;
    assign bus.out_illegal = s2_illegal;
    assign bus.sticky_o    = sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances (WIDTH 8, 32, 64) run in lockstep from
// one shared stimulus, each result compared against an arithmetic model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        o;
        logic        ill;
    } res_t;

    typedef res_t [2:0] trip_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        out_ready;
    logic        clr_sticky;

    res_t        o_r [3];
    logic [2:0]  o_valid;
    logic [2:0]  o_ready;
    logic [2:0]  o_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int W = (k == 0) ? 8 : ((k == 1) ? 32 : 64);
        alu_pipe_if #(.WIDTH(W)) bus ();
        alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign bus.in_valid   = in_valid;
        assign bus.in_opcode  = in_opcode;
        assign bus.in_a       = in_a[W-1:0];
        assign bus.in_b       = in_b[W-1:0];
        assign bus.in_cin     = in_cin;
        assign bus.out_ready  = out_ready;
        assign bus.clr_sticky = clr_sticky;
        assign o_r[k]     = {64'(bus.out_result), bus.out_z, bus.out_n, bus.out_c,
                             bus.out_o, bus.out_illegal};
        assign o_valid[k]  = bus.out_valid;
        assign o_ready[k]  = bus.in_ready;
        assign o_sticky[k] = bus.sticky_o;
    end

    function automatic int wof(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 32 : 64);
    endfunction

    function automatic string show(input res_t r);
        return $sformatf("res=%h zncoi=%b", r.res, {r.z, r.n, r.c, r.o, r.ill});
    endfunction

    // Reference: results computed directly from the opcode definitions at width w.
    function automatic res_t model(input logic [3:0] op, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic cin, input int w);
        res_t        r;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sx;
        logic [64:0] s;
        int          sh;
        logic        arith;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a     = a_in & mask;
        b     = b_in & mask;
        sh    = int'(b_in[5:0]) % w;
        r     = '0;
        s     = '0;
        arith = 1'b0;
        case (op)
            4'd0: begin s = 65'(a) + 65'(b);          r.c = s[w];   arith = 1'b1; end
            4'd1: begin s = 65'(a) - 65'(b);          r.c = (a >= b); arith = 1'b1; end
            4'd9: begin s = 65'(a) + 65'(b) + 65'(cin); r.c = s[w]; arith = 1'b1; end
            4'd2: r.res = a ^ b;
            4'd3: r.res = a & b;
            4'd4: r.res = a | b;
            4'd5: r.res = ~(a | b) & mask;
            4'd6: r.res = (a << sh) & mask;
            4'd7: r.res = a >> sh;
            4'd8: begin
                sx    = a[w-1] ? (a | ~mask) : a;
                r.res = 64'($signed(sx) >>> sh) & mask;
            end
            default: r.ill = 1'b1;
        endcase
        if (arith) begin
            r.res = s[63:0] & mask;
            if (op == 4'd1)
                r.o = (a[w-1] != b[w-1]) && (r.res[w-1] != a[w-1]);
            else
                r.o = (a[w-1] == b[w-1]) && (r.res[w-1] != a[w-1]);
        end
        r.z = (r.res == 64'd0);
        r.n = r.res[w-1];
        return r;
    endfunction

    function automatic trip_t model_all(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin);
        trip_t t;
        for (int k = 0; k < 3; k++) t[k] = model(op, a, b, cin, wof(k));
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
        in_cin = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b1 || o_sticky[k] !== 1'b0 || o_r[k] !== res_t'(0)) begin
                n_fail++;
                $display("[TB] FAIL reset_hold w=%0d got v/r/s=%b%b%b %s required v/r/s=010 all zero",
                         wof(k), o_valid[k], o_ready[k], o_sticky[k], show(o_r[k]));
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL after_reset w=%0d got valid=%b ready=%b required valid=0 ready=1",
                         wof(k), o_valid[k], o_ready[k]);
            end
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        res_t        exp32;
    } vec_t;

    task automatic test_directed();
        vec_t vecs [12];
        res_t exp;
        vecs[0]  = '{4'd0,  64'h7FFF_FFFF, 64'h1,         1'b0, {64'h8000_0000, 5'b01010}};
        vecs[1]  = '{4'd1,  64'h5,         64'h5,         1'b0, {64'h0,         5'b10100}};
        vecs[2]  = '{4'd1,  64'h0,         64'h1,         1'b0, {64'hFFFF_FFFF, 5'b01000}};
        vecs[3]  = '{4'd8,  64'h8000_0000, 64'h24,        1'b0, {64'hF800_0000, 5'b01000}};
        vecs[4]  = '{4'd7,  64'h8000_0000, 64'h24,        1'b0, {64'h0800_0000, 5'b00000}};
        vecs[5]  = '{4'd12, 64'h1234,      64'h5678,      1'b0, {64'h0,         5'b10001}};
        vecs[6]  = '{4'd9,  64'hFFFF_FFFF, 64'h0,         1'b1, {64'h0,         5'b10100}};
        vecs[7]  = '{4'd2,  64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, {64'h0FF0_0FF0, 5'b00000}};
        vecs[8]  = '{4'd3,  64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, {64'hF000_F000, 5'b01000}};
        vecs[9]  = '{4'd4,  64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, {64'hFFF0_FFF0, 5'b01000}};
        vecs[10] = '{4'd5,  64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, {64'h000F_000F, 5'b00000}};
        vecs[11] = '{4'd6,  64'h1,         64'h21,        1'b0, {64'h2,         5'b00000}};
        for (int i = 0; i < 12; i++) begin
            in_opcode = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin;
            in_valid = 1'b1; out_ready = 1'b1; clr_sticky = 1'b1;
            tick();
            in_valid = 1'b0; clr_sticky = 1'b0;
            settle();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_valid[k] !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL latency_early v%0d w=%0d got valid=%b required 0", i, wof(k), o_valid[k]);
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                exp = (k == 1) ? vecs[i].exp32 : model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, wof(k));
                n_tests++;
                if (o_valid[k] !== 1'b1 || o_r[k] !== exp || o_sticky[k] !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL directed v%0d w=%0d got valid=%b sticky=%b %s required valid=1 sticky=0 %s",
                             i, wof(k), o_valid[k], o_sticky[k], show(o_r[k]), show(exp));
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                exp = (k == 1) ? vecs[i].exp32 : model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, wof(k));
                n_tests++;
                if (o_valid[k] !== 1'b0 || o_sticky[k] !== exp.o) begin
                    n_fail++;
                    $display("[TB] FAIL directed_after v%0d w=%0d got valid=%b sticky=%b required valid=0 sticky=%b",
                             i, wof(k), o_valid[k], o_sticky[k], exp.o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        trip_t q[$];
        trip_t e;
        int    sent = 0;
        int    got  = 0;
        logic  acc;
        logic  xfer;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid  = (sent < 6);
            in_opcode = 4'd0;
            in_a      = 64'(sent + 1) * 64'h1111_1111_1111_1111;
            in_b      = 64'(sent + 1);
            in_cin    = 1'b0;
            if (c == 2 || c == 3) in_a = {$urandom, $urandom};
            out_ready = (c >= 4);
            settle();
            if (c == 2 || c == 3) begin
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL bp_stall c%0d w=%0d got nothing in flight required op1 held", c, wof(k));
                    end else if (o_ready[k] !== 1'b0 || o_valid[k] !== 1'b1 || o_r[k] !== q[0][k]) begin
                        n_fail++;
                        $display("[TB] FAIL bp_stall c%0d w=%0d got ready=%b valid=%b %s required ready=0 valid=1 %s",
                                 c, wof(k), o_ready[k], o_valid[k], show(o_r[k]), show(q[0][k]));
                    end
                end
            end
            if (c == 4) begin
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (o_ready[k] !== 1'b1) begin
                        n_fail++;
                        $display("[TB] FAIL bp_passthrough w=%0d got ready=%b required 1", wof(k), o_ready[k]);
                    end
                end
            end
            acc  = in_valid && o_ready[1];
            xfer = o_valid[1] && out_ready;
            if (xfer) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL bp_extra c%0d got unexpected output required none", c);
                end else begin
                    e = q.pop_front();
                    got++;
                    for (int k = 0; k < 3; k++) begin
                        n_tests++;
                        if (o_valid[k] !== 1'b1 || o_r[k] !== e[k]) begin
                            n_fail++;
                            $display("[TB] FAIL bp_order op%0d w=%0d got valid=%b %s required %s",
                                     got, wof(k), o_valid[k], show(o_r[k]), show(e[k]));
                        end
                    end
                end
            end
            if (acc) begin
                q.push_back(model_all(in_opcode, in_a, in_b, in_cin));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 6 || sent != 6) begin
            n_fail++;
            $display("[TB] FAIL bp_count got sent=%0d out=%0d required 6 and 6", sent, got);
        end
        settle();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_no_dup w=%0d got valid=%b required 0", wof(k), o_valid[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1; in_opcode = 4'd0; in_a = 64'h10; in_b = 64'h20; in_cin = 1'b0;
        tick();
        in_a = 64'h30;
        tick();
        in_valid = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b1 || o_ready[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rst_setup w=%0d got valid=%b ready=%b required valid=1 ready=0",
                         wof(k), o_valid[k], o_ready[k]);
            end
        end
        rst_n = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b1 || o_r[k] !== res_t'(0)) begin
                n_fail++;
                $display("[TB] FAIL rst_async w=%0d got valid=%b ready=%b %s required valid=0 ready=1 zero",
                         wof(k), o_valid[k], o_ready[k], show(o_r[k]));
            end
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL rst_stale c%0d w=%0d got valid=%b ready=%b required valid=0 ready=1",
                             c, wof(k), o_valid[k], o_ready[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_sticky();
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        settle();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_sticky[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL sticky_pre w=%0d got %b required 0", wof(k), o_sticky[k]);
            end
        end
        in_valid = 1'b1; in_opcode = 4'd0; in_cin = 1'b0;
        in_a = 64'h4040_4040_4040_4040; in_b = 64'h4040_4040_4040_4040;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_sticky[k] !== 1'b0 || o_valid[k] !== 1'b1 || o_r[k].o !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL sticky_stall w=%0d got sticky=%b valid=%b o=%b required sticky=0 valid=1 o=1",
                         wof(k), o_sticky[k], o_valid[k], o_r[k].o);
            end
        end
        out_ready = 1'b1; clr_sticky = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_sticky[k] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL sticky_set_wins w=%0d got %b required 1", wof(k), o_sticky[k]);
            end
        end
        tick();
        clr_sticky = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_sticky[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL sticky_clear w=%0d got %b required 0", wof(k), o_sticky[k]);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        trip_t      q[$];
        trip_t      e;
        res_t       prev_r [3];
        logic [2:0] sticky_m;
        logic       prev_stall;
        logic       acc;
        logic       xfer;
        logic       exp_ready;
        int         in_flight;
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
        tick();
        sticky_m   = '0;
        prev_stall = 1'b0;
        for (int c = 0; c < 3; c++) prev_r[c] = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_opcode  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            in_a       = {$urandom, $urandom};
            in_b       = ($urandom_range(0, 7) == 0) ? in_a : {$urandom, $urandom};
            in_cin     = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            settle();
            in_flight = q.size();
            exp_ready = (in_flight < 2) || out_ready;
            acc  = in_valid && o_ready[1];
            xfer = o_valid[1] && out_ready;
            e    = '0;
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_ready[k] !== exp_ready || o_sticky[k] !== sticky_m[k]
                    || (in_flight == 0 && o_valid[k] !== 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_ctrl cyc%0d w=%0d got ready=%b sticky=%b valid=%b required ready=%b sticky=%b inflight=%0d",
                             cyc, wof(k), o_ready[k], o_sticky[k], o_valid[k], exp_ready, sticky_m[k], in_flight);
                end
                if (prev_stall) begin
                    n_tests++;
                    if (o_valid[k] !== 1'b1 || o_r[k] !== prev_r[k]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_hold cyc%0d w=%0d got valid=%b %s required valid=1 %s",
                                 cyc, wof(k), o_valid[k], show(o_r[k]), show(prev_r[k]));
                    end
                end
            end
            if (xfer) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("[TB] FAIL rand_extra cyc%0d got unexpected output required none", cyc);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        n_tests++;
                        if (o_valid[k] !== 1'b1 || o_r[k] !== e[k]) begin
                            n_fail++;
                            $display("[TB] FAIL rand_result cyc%0d w=%0d got valid=%b %s required %s",
                                     cyc, wof(k), o_valid[k], show(o_r[k]), show(e[k]));
                        end
                    end
                end
            end
            if (acc) q.push_back(model_all(in_opcode, in_a, in_b, in_cin));
            for (int k = 0; k < 3; k++) begin
                sticky_m[k] = (sticky_m[k] && !clr_sticky) || (xfer && e[k].o);
                prev_r[k]   = o_r[k];
            end
            prev_stall = o_valid[1] && !out_ready;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            settle();
            if (o_valid[1]) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (o_r[k] !== e[k]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_drain w=%0d got %s required %s", wof(k), show(o_r[k]), show(e[k]));
                    end
                end
            end
            tick();
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL rand_drain_timeout got %0d left required 0", q.size());
        end
        settle();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_valid[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rand_idle w=%0d got valid=%b required 0", wof(k), o_valid[k]);
            end
        end
    endtask

    // Hard stop in case the pipe wedges in a way the bounded loops miss.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_sticky();
        test_reset_midflight();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle 32-bit ALU. It accepts one operation per cycle over a valid/ready handshake and computes add, subtract, add-with-carry, logic and shift operations at WIDTH bits. It returns the result with z/n/c/o flags two cycles later and keeps a sticky overflow status. It sits between the operand-fetch stage and writeback, and tolerates writeback back-pressure without losing or duplicating operations.

## Interface
- WIDTH, 32: operand/result width; ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from B[SHW-1:0].

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- in_opcode  in  4  operation select (map below).
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry-in, used only by ADC.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_result  out  WIDTH  result.
- out_z, out_n, out_c, out_o  out  1  zero, negative, carry, signed overflow.
- out_illegal  out  1  opcode was unmapped.
- clr_sticky  in  1  clear sticky_o.
- sticky_o  out  1  OR of out_o over all completed output transfers since the last clear.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 XOR, 3 AND, 4 OR, 5 NOR.
  - 6 SLL: A<<sh.
  - 7 SRL: logical A>>sh.
  - 8 SRA: arithmetic A>>>sh.
  - 9 ADC: A+B+cin.
  - 10–15: result 0, illegal=1.
- sh = B[SHW-1:0]; the upper bits of B are ignored for shifts.
- Arithmetic is done at WIDTH+1 bits.
  - c = bit WIDTH of the sum.
  - For SUB, c=1 means no borrow (A ≥ B unsigned).
- o:
  - ADD/ADC: A[MSB]==B[MSB] and result[MSB]!=A[MSB].
  - SUB: A[MSB]!=B[MSB] and result[MSB]!=A[MSB].
- Logic, shift and illegal opcodes: c=0, o=0.
- z = (result==0) and n = result[MSB] for every opcode, including illegal (z=1, n=0).
- Stage 1 (S1) registers opcode, operands and cin. Stage 2 (S2) registers result, flags and illegal.
- Advance rules:
  - S1 advances to S2 when s2 is empty or out_ready=1.
  - in_ready = !s1_valid | (!s2_valid | out_ready), combinational.
- Under stall (out_valid & !out_ready), all out_* hold stable and no transfer is lost or duplicated.
- sticky_o next value = (sticky_o & !clr_sticky) | (out_valid & out_ready & out_o). When a clear and a setting transfer happen in the same cycle, set wins.

## Timing
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, all flags 0, out_illegal=0, sticky_o=0. in_ready=1 during and after reset.
- Latency: an input accepted at edge k appears on out_valid after edge k+1, i.e. exactly 2 cycles with no stall.
- Throughput: 1 op/cycle while out_ready=1.
- Full pipeline: both stages valid and out_ready=0 ⇒ in_ready=0 in the same cycle. When out_ready rises, in_ready rises in the same cycle (pass-through).
- Reset asserted mid-operation discards all in-flight ops immediately. No output transfer occurs after reset.
- in_* are sampled only on an accepting edge. Changes on in_* while in_ready=0 have no effect.

## Structure
- Package alu_pipe_pkg holds:
  - the opcode enum (OP_ADD … OP_ADC);
  - a flags struct {z,n,c,o};
  - the constant OP_W=4.
- Sub-module alu_pipe_core: purely combinational datapath, taking (opcode, a, b, cin) and producing (result, flags, illegal), parametrised by WIDTH. It sits between S1 and S2.
- The top level holds only the two pipeline registers, the handshake and the sticky logic.

## Test plan
- ADD, WIDTH=32, A=0x7FFFFFFF, B=1, out_ready=1 → 2 cycles later: result 0x80000000, n=1, o=1, c=0, z=0; sticky_o=1 on the next edge.
- SUB A=5, B=5 → result 0, z=1, c=1, o=0. SUB A=0, B=1 → result 0xFFFFFFFF, n=1, c=0.
- SRA A=0x80000000, B=0x24 (sh=4) → 0xF8000000. SRL with the same inputs → 0x08000000. Opcode 12 → result 0, illegal=1, z=1.
- Back-pressure:
  - Stream ops 1..6 with out_ready=0 for 4 cycles → in_ready falls after 2 accepts, and out_* hold op 1.
  - Release out_ready → outputs appear in order with no loss or duplicates.
- Assert rst_n low with 2 ops in flight → out_valid=0 immediately; after release, no stale output appears and in_ready=1.
- clr_sticky asserted in the same cycle as an overflowing output transfer → sticky_o stays 1. clr_sticky alone → 0 next cycle. Repeat at WIDTH=8 and WIDTH=64.
